// File: rtl/decred_spi_pkg.sv
// Shared types and frame geometry for the decred SPI host.
package decred_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_e;

  localparam int FRAME_W   = 16;
  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 8;
  localparam int WRITE_BIT = 15;

  // Reads carry an all-zero data byte so the slave sees a clean frame.
  function automatic logic [FRAME_W-1:0] build_frame(input logic wr,
                                                     input logic [ADDR_W-1:0] addr,
                                                     input logic [DATA_W-1:0] wdata);
    return {wr, addr, (wr ? wdata : {DATA_W{1'b0}})};
  endfunction

endpackage

// File: rtl/decred_spi_sclk_gen.sv
// Half-period counter: times every FSM state and, while enabled, toggles SCLK.
// rise/fall mark the first cycle of each SCLK high/low half; done marks the last cycle of a count.
module decred_spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reload,
  input  logic [7:0] load_val,
  input  logic       sclk_start,
  input  logic       sclk_en,
  output logic       sclk,
  output logic       rise,
  output logic       fall,
  output logic       done
);

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       sclk_q, sclk_d;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (reload) begin
      cnt_d  = load_val;
      sclk_d = sclk_start;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end else if (sclk_en) begin
      cnt_d  = HALF_LAST;
      sclk_d = ~sclk_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 8'd0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;
  assign done = (cnt_q == 8'd0);
  assign rise = sclk_en && sclk_q && (cnt_q == HALF_LAST);
  assign fall = sclk_en && !sclk_q && (cnt_q == HALF_LAST);

endmodule

// File: rtl/decred_spi_host.sv
// Mode-0 SPI initiator: one 16-bit register frame per request, rsp_valid 34*CLK_DIV+1 cycles after accept.
// req_ready is low from accept through the CS gap; IRQ synchronizer built only with DECRED_SPI_IRQ_SYNC_EN.
module decred_spi_host
  import decred_spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic       SPI_CLK,
  input  logic       RESET,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       SCSN_toClient,
  output logic       SCLK_toClient,
  output logic       MOSI_toClient,
  input  logic       MISO_fromClient,
  input  logic       IRQ_OUT_fromClient,
  input  logic       irq_clear,
  output logic       irq_pending
);

  localparam logic [7:0] HALF_LOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(CS_GAP - 1);
  localparam logic [4:0] LAST_BIT  = 5'(FRAME_W - 1);

  state_e              state_q, state_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;

  logic       reload, sclk_start, sclk_en, sclk, rise, fall, hp_done;
  logic [7:0] load_val;
  logic       accept, last_period, mosi_adv, cs_active;

  assign req_ready   = (state_q == ST_IDLE) && !RESET;
  assign accept      = req_valid && req_ready;
  assign sclk_en     = (state_q == ST_SHIFT);
  assign last_period = (bit_cnt_q == LAST_BIT);
  // MOSI moves to the next bit within the falling cycle itself, ahead of the register shift.
  assign mosi_adv    = sclk_en && fall && !last_period;
  assign cs_active   = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SETUP;
      ST_SETUP: if (hp_done) state_d = ST_SHIFT;
      ST_SHIFT: if (hp_done && !sclk && last_period) state_d = ST_HOLD;
      ST_HOLD:  if (hp_done) state_d = ST_GAP;
      ST_GAP:   if (hp_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    reload      = (state_d != state_q);
    sclk_start  = (state_d == ST_SHIFT);
    load_val    = 8'd0;
    case (state_d)
      ST_SETUP, ST_SHIFT, ST_HOLD: load_val = HALF_LOAD;
      ST_GAP:                      load_val = GAP_LOAD;
      default:                     load_val = 8'd0;
    endcase

    frame_d = frame_q;
    if (accept) begin
      frame_d = build_frame(req_write, req_addr, req_wdata);
    end else if (mosi_adv) begin
      frame_d = {frame_q[FRAME_W-2:0], 1'b0};
    end

    bit_cnt_d = bit_cnt_q;
    if (reload) begin
      bit_cnt_d = 5'd0;
    end else if (sclk_en && hp_done && !sclk) begin
      bit_cnt_d = bit_cnt_q + 5'd1;
    end

    // Only the last eight samples survive, which is exactly the data byte.
    rx_d = rx_q;
    if (sclk_en && rise) rx_d = {rx_q[DATA_W-2:0], MISO_fromClient};

    rsp_valid_d = (state_q == ST_HOLD) && hp_done;
    rdata_d     = rsp_valid_d ? rx_q : rdata_q;
  end

  always_ff @(posedge SPI_CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      frame_q     <= '0;
      rx_q        <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      bit_cnt_q   <= 5'd0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      rx_q        <= rx_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  decred_spi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk       (SPI_CLK),
    .rst       (RESET),
    .reload    (reload),
    .load_val  (load_val),
    .sclk_start(sclk_start),
    .sclk_en   (sclk_en),
    .sclk      (sclk),
    .rise      (rise),
    .fall      (fall),
    .done      (hp_done)
  );

  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rdata_q;
  assign busy          = (state_q != ST_IDLE);
  assign SCSN_toClient = !cs_active;
  assign SCLK_toClient = sclk;
  assign MOSI_toClient = cs_active && (mosi_adv ? frame_q[WRITE_BIT-1] : frame_q[WRITE_BIT]);

`ifdef DECRED_SPI_IRQ_SYNC_EN
  // {previous, stage 2, stage 1}; a set edge beats a simultaneous clear.
  logic [2:0] irq_sync_q, irq_sync_d;
  logic       irq_pend_q, irq_pend_d;

  always_comb begin
    irq_sync_d = {irq_sync_q[1:0], IRQ_OUT_fromClient};
    irq_pend_d = irq_pend_q;
    if (irq_clear) irq_pend_d = 1'b0;
    if (irq_sync_q[1] && !irq_sync_q[2]) irq_pend_d = 1'b1;
  end

  always_ff @(posedge SPI_CLK) begin
    if (RESET) begin
      irq_sync_q <= 3'b000;
      irq_pend_q <= 1'b0;
    end else begin
      irq_sync_q <= irq_sync_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  assign irq_pending = irq_pend_q;
`else
  logic unused_irq;
  assign unused_irq  = IRQ_OUT_fromClient ^ irq_clear;
  assign irq_pending = 1'b0;
`endif

endmodule

// File: tb/tb_decred_spi_host.sv
// Bench for decred_spi_host: an SPI slave model and frame-level timing model for CLK_DIV=4 and CLK_DIV=1 instances.
module tb_decred_spi_host;

`ifdef DECRED_SPI_IRQ_SYNC_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  localparam int CS_GAP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst;
  logic       req_valid [2];
  logic       req_write [2];
  logic [6:0] req_addr  [2];
  logic [7:0] req_wdata [2];
  logic       miso      [2];
  logic       irq_in    [2];
  logic       irq_clr   [2];
  logic       req_ready [2];
  logic       rsp_valid [2];
  logic [7:0] rsp_rdata [2];
  logic       busy      [2];
  logic       scsn      [2];
  logic       sclk      [2];
  logic       mosi      [2];
  logic       irq_pend  [2];

  int vectors = 0;
  int miscompares = 0;

  decred_spi_host #(.CLK_DIV(4), .CS_GAP(CS_GAP)) u_dut4 (
    .SPI_CLK(clk), .RESET(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
    .SCSN_toClient(scsn[0]), .SCLK_toClient(sclk[0]), .MOSI_toClient(mosi[0]),
    .MISO_fromClient(miso[0]), .IRQ_OUT_fromClient(irq_in[0]),
    .irq_clear(irq_clr[0]), .irq_pending(irq_pend[0])
  );

  decred_spi_host #(.CLK_DIV(1), .CS_GAP(CS_GAP)) u_dut1 (
    .SPI_CLK(clk), .RESET(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
    .SCSN_toClient(scsn[1]), .SCLK_toClient(sclk[1]), .MOSI_toClient(mosi[1]),
    .MISO_fromClient(miso[1]), .IRQ_OUT_fromClient(irq_in[1]),
    .irq_clear(irq_clr[1]), .irq_pending(irq_pend[1])
  );

  // One request on instance s, observed pin by pin until the end of the CS gap minus one cycle,
  // so a following call can still hit the very first ready cycle.
  task automatic run_txn(input int s, input bit wr, input logic [6:0] addr, input logic [7:0] wdata,
                         input logic [15:0] resp, input bit keep_valid,
                         output int t_acc, output int t_rsp);
    int d, waited, nrise, low_cnt, first_low, rsp_at, rsp_cnt, bad;
    logic [15:0] exp_frame, got;
    logic [7:0] rdata;
    logic prev;
    d = (s == 0) ? 4 : 1;
    exp_frame = {wr, addr, (wr ? wdata : 8'h00)};
    @(negedge clk);
    req_write[s] = wr; req_addr[s] = addr; req_wdata[s] = wdata; req_valid[s] = 1'b1;
    miso[s] = resp[15];
    waited = 0;
    while (!req_ready[s] && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (!req_ready[s]) begin
      miscompares++;
      $display("FAIL accept_timeout: req_ready stayed %0b, required 1", req_ready[s]);
      req_valid[s] = 1'b0;
      t_acc = -1; t_rsp = -1;
      return;
    end
    t_acc = cyc;
    nrise = 0; low_cnt = 0; first_low = -1; rsp_at = -1; rsp_cnt = 0; bad = 0;
    got = 16'h0; rdata = 8'h0; prev = 1'b0;
    for (int c = 1; c <= 34*d + CS_GAP; c++) begin
      @(negedge clk);
      if (c == 1 && !keep_valid) req_valid[s] = 1'b0;
      if (!scsn[s]) begin
        low_cnt++;
        if (first_low < 0) first_low = c;
      end
      if (sclk[s] && !prev) begin
        if (nrise < 16) got[15-nrise] = mosi[s];
        nrise++;
      end
      if (sclk[s] && scsn[s]) bad++;
      prev = sclk[s];
      if (!sclk[s]) miso[s] = (nrise < 16) ? resp[15-nrise] : 1'b0;
      if (rsp_valid[s]) begin
        rsp_cnt++;
        rsp_at = c;
        rdata = rsp_rdata[s];
      end
    end
    t_rsp = t_acc + rsp_at;
    vectors++; if (got !== exp_frame) begin miscompares++;
      $display("FAIL mosi_frame: got %04h required %04h", got, exp_frame); end
    vectors++; if (nrise != 16) begin miscompares++;
      $display("FAIL sclk_rises: got %0d required 16", nrise); end
    vectors++; if (low_cnt != 34*d) begin miscompares++;
      $display("FAIL scsn_low_cycles: got %0d required %0d", low_cnt, 34*d); end
    vectors++; if (first_low != 1) begin miscompares++;
      $display("FAIL scsn_fall_offset: got %0d required 1", first_low); end
    vectors++; if (rsp_at != 34*d + 1) begin miscompares++;
      $display("FAIL rsp_valid_offset: got %0d required %0d", rsp_at, 34*d + 1); end
    vectors++; if (rsp_cnt != 1) begin miscompares++;
      $display("FAIL rsp_valid_pulses: got %0d required 1", rsp_cnt); end
    vectors++; if (rdata !== resp[7:0]) begin miscompares++;
      $display("FAIL rsp_rdata: got %02h required %02h", rdata, resp[7:0]); end
    vectors++; if (bad != 0) begin miscompares++;
      $display("FAIL sclk_while_deselected: got %0d cycles required 0", bad); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      vectors++;
      if ({req_ready[s], scsn[s], sclk[s], mosi[s], rsp_valid[s], rsp_rdata[s], busy[s], irq_pend[s]}
          !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL reset_values[%0d]: got rdy=%b cs=%b sclk=%b mosi=%b v=%b d=%02h busy=%b irq=%b", s,
                 req_ready[s], scsn[s], sclk[s], mosi[s], rsp_valid[s], rsp_rdata[s], busy[s], irq_pend[s]);
      end
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (req_ready[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset: got %b required 1", req_ready[0]);
    end
  endtask

  task automatic test_write_read();
    int ta, tr;
    logic [15:0] r;
    r = 16'($urandom);
    run_txn(0, 1'b1, 7'h12, 8'hA5, r, 1'b0, ta, tr);
    r = {8'($urandom), 8'h3C};
    run_txn(0, 1'b0, 7'h05, 8'($urandom), r, 1'b0, ta, tr);
  endtask

  task automatic test_back_to_back();
    int ta1, tr1, ta2, tr2;
    run_txn(0, 1'b1, 7'h2A, 8'h5A, 16'($urandom), 1'b1, ta1, tr1);
    run_txn(0, 1'b1, 7'h55, 8'hC3, 16'($urandom), 1'b0, ta2, tr2);
    vectors++;
    if (ta2 != ta1 + 34*4 + 1 + CS_GAP) begin
      miscompares++;
      $display("FAIL b2b_accept: got t+%0d required t+%0d", ta2 - ta1, 34*4 + 1 + CS_GAP);
    end
    vectors++;
    if ((ta2 + 1) - tr1 != 3) begin
      miscompares++;
      $display("FAIL b2b_cs_high: got %0d cycles required 3", (ta2 + 1) - tr1);
    end
  endtask

  task automatic test_reset_midframe();
    int waited, nrise, vcount, ta, tr;
    logic prev;
    @(negedge clk);
    req_write[0] = 1'b1; req_addr[0] = 7'h33; req_wdata[0] = 8'h44; req_valid[0] = 1'b1;
    waited = 0;
    while (!req_ready[0] && waited < 400) begin @(negedge clk); waited++; end
    @(negedge clk);
    req_valid[0] = 1'b0;
    nrise = 0; prev = 1'b0; waited = 0;
    while (nrise < 7 && waited < 400) begin
      if (sclk[0] && !prev) nrise++;
      prev = sclk[0];
      if (nrise < 7) begin @(negedge clk); waited++; end
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({scsn[0], sclk[0], busy[0]} !== 3'b100) begin
      miscompares++;
      $display("FAIL midframe_reset: got cs=%b sclk=%b busy=%b required 1/0/0 (rises seen %0d)",
               scsn[0], sclk[0], busy[0], nrise);
    end
    vcount = 0;
    repeat (150) begin
      @(negedge clk);
      if (rsp_valid[0]) vcount++;
    end
    vectors++;
    if (vcount != 0) begin
      miscompares++;
      $display("FAIL aborted_rsp_valid: got %0d pulses required 0", vcount);
    end
    run_txn(0, 1'b1, 7'h01, 8'hFF, 16'($urandom), 1'b0, ta, tr);
  endtask

  task automatic test_clkdiv1();
    int ta, tr;
    run_txn(1, 1'b1, 7'h7F, 8'h00, 16'($urandom), 1'b0, ta, tr);
  endtask

  task automatic test_random();
    int ta, tr;
    for (int i = 0; i < 6; i++)
      run_txn(0, 1'($urandom), 7'($urandom), 8'($urandom), 16'($urandom), 1'b0, ta, tr);
    for (int i = 0; i < 3; i++)
      run_txn(1, 1'($urandom), 7'($urandom), 8'($urandom), 16'($urandom), 1'b0, ta, tr);
  endtask

  task automatic test_irq();
    logic exp_set;
    exp_set = IRQ_EN;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    irq_in[0] = 1'b1;
    @(negedge clk);
    irq_in[0] = 1'b0;
    vectors++; if (irq_pend[0] !== 1'b0) begin miscompares++;
      $display("FAIL irq_edge1: got %b required 0", irq_pend[0]); end
    @(negedge clk);
    vectors++; if (irq_pend[0] !== 1'b0) begin miscompares++;
      $display("FAIL irq_edge2: got %b required 0", irq_pend[0]); end
    @(negedge clk);
    vectors++; if (irq_pend[0] !== exp_set) begin miscompares++;
      $display("FAIL irq_edge3: got %b required %b", irq_pend[0], exp_set); end
    repeat (5) @(negedge clk);
    vectors++; if (irq_pend[0] !== exp_set) begin miscompares++;
      $display("FAIL irq_hold: got %b required %b", irq_pend[0], exp_set); end
    irq_clr[0] = 1'b1;
    @(negedge clk);
    irq_clr[0] = 1'b0;
    vectors++; if (irq_pend[0] !== 1'b0) begin miscompares++;
      $display("FAIL irq_clear: got %b required 0", irq_pend[0]); end
    irq_in[0] = 1'b1;
    @(negedge clk);
    irq_in[0] = 1'b0;
    @(negedge clk);
    irq_clr[0] = 1'b1;
    @(negedge clk);
    irq_clr[0] = 1'b0;
    vectors++; if (irq_pend[0] !== exp_set) begin miscompares++;
      $display("FAIL irq_set_beats_clear: got %b required %b", irq_pend[0], exp_set); end
  endtask

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_write[s] = 1'b0; req_addr[s] = 7'h0; req_wdata[s] = 8'h0;
      miso[s] = 1'b0; irq_in[s] = 1'b0; irq_clr[s] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_back_to_back();
    test_reset_midframe();
    test_clkdiv1();
    test_random();
    test_irq();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached with %0d vectors applied", vectors);
    $fatal(1, "watchdog");
  end

endmodule
